// File: rtl/sort_pkg.sv
// Shared definitions for the bitonic sort controller and its sorter network.
package sort_pkg;

  localparam int unsigned FRAME = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/bitonic_sorter.sv
// Combinational 8-input bitonic sorting network, ascending, signed compare.
module bitonic_sorter
  import sort_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [N-1:0] data_i [FRAME],
  output logic signed [N-1:0] data_o [FRAME]
);

  // Clock and reset are part of the common block interface only.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  logic signed [N-1:0] v [FRAME];
  logic signed [N-1:0] a, b;

  // Classic k/j bitonic schedule; block direction comes from bit k of the lane index.
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 0; i < FRAME; i++) v[IDX_W'(i)] = data_i[IDX_W'(i)];
    for (int k = 2; k <= FRAME; k = k * 2) begin
      for (int j = k / 2; j > 0; j = j / 2) begin
        for (int i = 0; i < FRAME; i++) begin
          if ((i ^ j) > i) begin
            a = v[IDX_W'(i)];
            b = v[IDX_W'(i ^ j)];
            if (((i & k) == 0) ? (a > b) : (a < b)) begin
              v[IDX_W'(i)]     = b;
              v[IDX_W'(i ^ j)] = a;
            end
          end
        end
      end
    end
    for (int i = 0; i < FRAME; i++) data_o[IDX_W'(i)] = v[IDX_W'(i)];
  end

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Serial gather -> one-cycle bitonic sort -> serial replay, valid/ready on both sides.
module bitonic_sort_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned FRAME = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  input  logic                in_valid,
  input  logic signed [N-1:0] in_data,
  input  logic                in_desc,
  output logic                in_ready,
  output logic                out_valid,
  output logic signed [N-1:0] out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                busy
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(sort_pkg::FRAME - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    cnt_q, idx_q;
  logic                desc_q;
  logic                out_valid_q;
  logic signed [N-1:0] in_buf  [sort_pkg::FRAME];
  logic signed [N-1:0] out_buf [sort_pkg::FRAME];
  logic signed [N-1:0] sorted  [sort_pkg::FRAME];

  bitonic_sorter #(
    .N(N)
  ) u_sorter (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(in_buf),
    .data_o(sorted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      desc_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < sort_pkg::FRAME; i++) begin
        in_buf[IDX_W'(i)]  <= '0;
        out_buf[IDX_W'(i)] <= '0;
      end
    end else if (abort) begin
      // Buffers are left untouched; only the sequencing is discarded.
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            in_buf[cnt_q] <= in_data;
            if (cnt_q == '0) desc_q <= in_desc;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastIdx) state_q <= S_SORT;
          end
        end
        S_SORT: begin
          for (int i = 0; i < sort_pkg::FRAME; i++) out_buf[IDX_W'(i)] <= sorted[IDX_W'(i)];
          state_q     <= S_DRAIN;
          out_valid_q <= 1'b1;
        end
        S_DRAIN: begin
          if (out_ready) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              state_q     <= S_LOAD;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (idx_q == LastIdx);
  // ~idx_q is 7-idx for the 3-bit index: descending replay of the ascending buffer.
  assign out_data  = desc_q ? out_buf[~idx_q] : out_buf[idx_q];
  assign busy      = (cnt_q != '0) || (state_q != S_LOAD);

  frame_fixed: assert property (@(posedge clk) FRAME == sort_pkg::FRAME);

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed and random scoreboard bench for bitonic_sort_ctrl.
module tb_bitonic_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_desc = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        busy;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitonic_sort_ctrl #(
    .N    (16),
    .FRAME(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_desc  (in_desc),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Drive n words; a complete frame pushes its reference-sorted result to the scoreboard.
  task automatic send_words(input int n, input logic [15:0] w [8], input logic desc,
                            input int gap, output int last_acc);
    logic [15:0] s [8];
    logic [15:0] t;
    int          to;
    int          g;
    last_acc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g = 0;
      while (gap > 0 && $urandom_range(0, 99) < gap && g < 6) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        @(negedge clk);
        g++;
      end
      in_valid = 1'b1;
      in_data  = w[i];
      in_desc  = (i == 0) ? desc : ((gap > 0) ? 1'($urandom) : 1'b0);
      to = 0;
      while (!in_ready && to < 100) begin
        @(negedge clk);
        to++;
      end
      if (to >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
      last_acc = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_desc  = 1'b0;
    if (n == 8) begin
      for (int i = 0; i < 8; i++) s[i] = w[i];
      for (int i = 1; i < 8; i++) begin
        for (int j = i; j > 0 && $signed(s[j-1]) > $signed(s[j]); j--) begin
          t      = s[j];
          s[j]   = s[j-1];
          s[j-1] = t;
        end
      end
      for (int i = 0; i < 8; i++) exp_q.push_back(desc ? s[7-i] : s[i]);
    end
  endtask

  // mode 0: always ready, 1: toggle every cycle, 2: random
  task automatic recv_words(input int n, input int mode, input bit chk_inrdy,
                            output int first_cyc);
    int got = 0;
    int to = 0;
    bit tog = 1'b1;
    first_cyc = -1;
    while (got < n && to < 400) begin
      @(negedge clk);
      to++;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
      tog = ~tog;
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (chk_inrdy) check("in_ready_drain", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          check("out_last", 32'(out_last), 32'(got == 7));
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
    end
    if (got < n) check("out_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    logic [15:0] d1 [8];
    logic [15:0] d4 [8];
    logic [15:0] r  [8];
    int          acc;
    int          fst;

    d1 = '{16'd5, 16'hFFFD, 16'd7, 16'd0, 16'd2, 16'hFFF8, 16'd1, 16'd4};
    d4 = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0001, 16'hFFFF};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // 1: ascending, latency
    send_words(8, d1, 1'b0, 0, acc);
    recv_words(8, 0, 1'b0, fst);
    check("latency", 32'(fst - acc), 32'd2);
    @(negedge clk);
    check("idle_after_frame", 32'(busy), 32'd0);

    // 2: descending
    send_words(8, d1, 1'b1, 0, acc);
    recv_words(8, 0, 1'b0, fst);

    // 3: backpressure with input gaps
    send_words(8, d1, 1'b0, 40, acc);
    recv_words(8, 1, 1'b1, fst);

    // 4: extremes
    send_words(8, d4, 1'b0, 0, acc);
    recv_words(8, 0, 1'b0, fst);

    // 5: abort after five words, then a full frame
    send_words(5, d4, 1'b1, 0, acc);
    check("busy_partial", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    send_words(8, d1, 1'b0, 0, acc);
    recv_words(8, 0, 1'b0, fst);

    // 6: reset during drain at idx 3
    send_words(8, d4, 1'b1, 0, acc);
    recv_words(3, 0, 1'b0, fst);
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_words(8, d1, 1'b1, 0, acc);
    recv_words(8, 0, 1'b0, fst);

    // Random frames with gaps on both sides
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 11))
          0:       r[i] = 16'h7FFF;
          1:       r[i] = 16'h8000;
          2:       r[i] = 16'hFFFF;
          3:       r[i] = 16'h0000;
          default: r[i] = 16'($urandom);
        endcase
      end
      send_words(8, r, 1'($urandom), 25, acc);
      recv_words(8, 2, 1'b0, fst);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
